// File: rtl/output_display_driver.sv
// Four-digit hex readout of the CPU output register on a multiplexed, active-low
// common-anode 7-segment display, with change flash on digit 0's decimal point.
module output_display_driver #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned HOLD_FRAMES = 50
) (
  input  logic        CLK,
  input  logic        ACLR_L,
  input  logic        SLOW_CLOCK_STRB,
  input  logic        OUT_LOAD,
  input  logic [15:0] OUT_VAL,
  input  logic        BLANK_LZ,
  output logic [3:0]  AN_L,
  output logic [6:0]  SEG_L,
  output logic        DP_L
);

  localparam int unsigned DIV_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned FLASH_W = $clog2(HOLD_FRAMES + 1);
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(REFRESH_DIV - 1);
  localparam logic [FLASH_W-1:0] FLASH_LOAD = FLASH_W'(HOLD_FRAMES);

  logic [15:0]        shadow;
  logic               load_pend;
  logic [DIV_W-1:0]   div_cnt;
  logic [1:0]         dig;
  logic [FLASH_W-1:0] flash_cnt;

  logic               div_wrap_c;
  logic               frame_wrap_c;
  logic               changed_c;
  logic [3:0]         nibble_c;
  logic               blank_c;
  logic [3:0]         an_c;
  logic [6:0]         seg_c;
  logic               dp_c;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  assign div_wrap_c   = (div_cnt == DIV_LAST);
  assign frame_wrap_c = div_wrap_c && (dig == 2'd3);
  assign changed_c    = load_pend && (OUT_VAL != shadow);

  // Capture: strobe cycle arms, following cycle samples the freshly loaded register
  always_ff @(posedge CLK or negedge ACLR_L) begin
    if (!ACLR_L) begin
      shadow    <= 16'h0000;
      load_pend <= 1'b0;
    end else begin
      load_pend <= SLOW_CLOCK_STRB && OUT_LOAD;
      if (load_pend) shadow <= OUT_VAL;
    end
  end

  // Digit multiplex timing
  always_ff @(posedge CLK or negedge ACLR_L) begin
    if (!ACLR_L) begin
      div_cnt <= '0;
      dig     <= 2'd0;
    end else begin
      div_cnt <= div_wrap_c ? '0 : div_cnt + DIV_W'(1);
      if (div_wrap_c) dig <= dig + 2'd1;
    end
  end

  // Change indicator; a reload beats the end-of-frame decrement
  always_ff @(posedge CLK or negedge ACLR_L) begin
    if (!ACLR_L) begin
      flash_cnt <= '0;
    end else if (changed_c) begin
      flash_cnt <= FLASH_LOAD;
    end else if (frame_wrap_c && (flash_cnt != '0)) begin
      flash_cnt <= flash_cnt - FLASH_W'(1);
    end
  end

  always_comb begin
    nibble_c = shadow[3:0];
    blank_c  = 1'b0;
    case (dig)
      2'd1: begin
        nibble_c = shadow[7:4];
        blank_c  = BLANK_LZ && (shadow[15:4] == 12'h000);
      end
      2'd2: begin
        nibble_c = shadow[11:8];
        blank_c  = BLANK_LZ && (shadow[15:8] == 8'h00);
      end
      2'd3: begin
        nibble_c = shadow[15:12];
        blank_c  = BLANK_LZ && (shadow[15:12] == 4'h0);
      end
      default: ;
    endcase
    an_c  = ~(4'b0001 << dig);
    seg_c = blank_c ? 7'h7F : hex7(nibble_c);
    dp_c  = !((dig == 2'd0) && (flash_cnt != '0));
  end

  always_ff @(posedge CLK or negedge ACLR_L) begin
    if (!ACLR_L) begin
      AN_L  <= 4'b1111;
      SEG_L <= 7'h7F;
      DP_L  <= 1'b1;
    end else begin
      AN_L  <= an_c;
      SEG_L <= seg_c;
      DP_L  <= dp_c;
    end
  end

endmodule

// File: tb/tb_output_display_driver.sv
// Scoreboard bench: stimulus queues one expected {anode,segments,dp} per digit slot;
// the monitor pops one entry each time the anode pattern changes.
module tb_output_display_driver;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic        clk = 1'b0;
  logic        aclr_l = 1'b1;
  logic        strb = 1'b0;
  logic        out_load = 1'b0;
  logic [15:0] out_val = 16'h0000;
  logic        blank_lz = 1'b0;
  logic [3:0]  an_l;
  logic [6:0]  seg_l;
  logic        dp_l;

  exp_t        exp_q[$];
  exp_t        e;
  logic [3:0]  prev_an = 4'b0000;
  int          edge_cnt = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          slot = 0;
  logic        done = 1'b0;

  output_display_driver #(.REFRESH_DIV(4), .HOLD_FRAMES(2)) dut (
    .CLK(clk), .ACLR_L(aclr_l), .SLOW_CLOCK_STRB(strb), .OUT_LOAD(out_load),
    .OUT_VAL(out_val), .BLANK_LZ(blank_lz), .AN_L(an_l), .SEG_L(seg_l), .DP_L(dp_l)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge aclr_l) begin
    if (!aclr_l) edge_cnt <= 0;
    else         edge_cnt <= edge_cnt + 1;
  end

  task automatic step_to(input int n);
    while (edge_cnt != n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_reset();
    exp_q.push_back('{an: 4'b1111, seg: 7'h7F, dp: 1'b1});
  endtask

  task automatic push_frame(input logic [6:0] s3, input logic [6:0] s2,
                            input logic [6:0] s1, input logic [6:0] s0, input logic dp0);
    exp_q.push_back('{an: 4'b1110, seg: s0, dp: dp0});
    exp_q.push_back('{an: 4'b1101, seg: s1, dp: 1'b1});
    exp_q.push_back('{an: 4'b1011, seg: s2, dp: 1'b1});
    exp_q.push_back('{an: 4'b0111, seg: s3, dp: 1'b1});
  endtask

  // Strobe lands so the capture edge is the last edge of frame f
  task automatic capture(input int f, input logic [15:0] val, input logic ld, input logic blank);
    step_to(16 * f + 14);
    strb     = 1'b1;
    out_load = ld;
    step_to(16 * f + 15);
    strb     = 1'b0;
    out_load = 1'b0;
    out_val  = val;
    blank_lz = blank;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    out_val = 16'h1234;
    push_reset();
    push_frame(7'h40, 7'h40, 7'h40, 7'h40, 1'b1);
    #1 aclr_l = 1'b0;
    repeat (3) @(posedge clk);
    #1 aclr_l = 1'b1;

    capture(0, 16'hBEEF, 1'b1, 1'b0);
    push_frame(7'h03, 7'h06, 7'h06, 7'h0E, 1'b0);
    push_frame(7'h03, 7'h06, 7'h06, 7'h0E, 1'b0);
    push_frame(7'h03, 7'h06, 7'h06, 7'h0E, 1'b1);
    push_frame(7'h03, 7'h06, 7'h06, 7'h0E, 1'b1);

    capture(4, 16'h0005, 1'b1, 1'b1);
    push_frame(7'h7F, 7'h7F, 7'h7F, 7'h12, 1'b0);
    push_frame(7'h7F, 7'h7F, 7'h7F, 7'h12, 1'b0);
    step_to(112);
    blank_lz = 1'b0;
    push_frame(7'h40, 7'h40, 7'h40, 7'h12, 1'b1);

    capture(7, 16'hABCD, 1'b0, 1'b0);
    push_frame(7'h40, 7'h40, 7'h40, 7'h12, 1'b1);
    capture(8, 16'h0005, 1'b1, 1'b0);
    push_frame(7'h40, 7'h40, 7'h40, 7'h12, 1'b1);

    capture(9, 16'h00A0, 1'b1, 1'b0);
    push_frame(7'h40, 7'h40, 7'h08, 7'h40, 1'b0);
    capture(10, 16'h0305, 1'b1, 1'b1);
    push_frame(7'h7F, 7'h30, 7'h40, 7'h12, 1'b0);
    push_frame(7'h7F, 7'h30, 7'h40, 7'h12, 1'b0);
    push_frame(7'h7F, 7'h30, 7'h40, 7'h12, 1'b1);

    capture(13, 16'h6789, 1'b1, 1'b1);
    push_frame(7'h02, 7'h78, 7'h00, 7'h10, 1'b0);
    push_frame(7'h02, 7'h78, 7'h00, 7'h10, 1'b0);
    capture(15, 16'h14CD, 1'b1, 1'b1);
    push_frame(7'h79, 7'h19, 7'h46, 7'h21, 1'b0);
    push_frame(7'h79, 7'h19, 7'h46, 7'h21, 1'b0);
    push_frame(7'h79, 7'h19, 7'h46, 7'h21, 1'b1);

    // Reset one cycle after a loading strobe: capture must be lost
    step_to(302);
    strb     = 1'b1;
    out_load = 1'b1;
    step_to(303);
    strb     = 1'b0;
    out_load = 1'b0;
    out_val  = 16'h5555;
    push_reset();
    aclr_l   = 1'b0;
    repeat (3) @(posedge clk);
    push_frame(7'h7F, 7'h7F, 7'h7F, 7'h40, 1'b1);
    push_frame(7'h7F, 7'h7F, 7'h7F, 7'h40, 1'b1);
    #1 aclr_l = 1'b1;
    step_to(32);
    done = 1'b1;
  end

  always @(negedge clk) begin
    if (done) begin
      n_cmp++;
      if (exp_q.size() != 0) begin
        n_err++;
        $display("FAIL leftover_expect: %0d slots not presented, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
    end else if (an_l !== prev_an) begin
      prev_an = an_l;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_slot: an=%b seg=%h dp=%b, required no further slot",
                 an_l, seg_l, dp_l);
      end else begin
        e = exp_q.pop_front();
        if ({an_l, seg_l, dp_l} !== e) begin
          n_err++;
          $display("FAIL slot%0d: an=%b seg=%h dp=%b, required an=%b seg=%h dp=%b",
                   slot, an_l, seg_l, dp_l, e.an, e.seg, e.dp);
        end
        slot++;
      end
    end
  end

endmodule
